// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: RV32I load/store funct3 values,
// stage state enum and exception codes.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [1:0] EXC_NONE        = 2'b00;
  localparam logic [1:0] EXC_LD_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ST_MISALIGN = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL     = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store alignment: byte enables, store-lane replication,
// access legality checks and load-lane extraction with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rs2,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_illegal,
  output logic        o_misalign,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic       w_ld_ok;
  logic       w_st_ok;
  logic       w_half;
  logic       w_word;
  logic [7:0] w_byte;
  logic [15:0] w_hword;

  always_comb begin
    w_ld_ok = i_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    w_st_ok = i_funct3 inside {F3_SB, F3_SH, F3_SW};
    w_half  = (i_funct3[1:0] == F3_LH[1:0]);
    w_word  = (i_funct3[1:0] == F3_LW[1:0]);

    o_illegal  = (i_mem_read && i_mem_write) ||
                 (i_mem_read && !w_ld_ok) ||
                 (i_mem_write && !w_st_ok);
    o_misalign = (i_mem_read || i_mem_write) &&
                 ((w_half && i_addr_lo[0]) || (w_word && (i_addr_lo != 2'b00)));

    unique case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_rs2[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_rs2[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_rs2;
      end
    endcase
  end

  always_comb begin
    w_byte  = i_rdata[{i_ld_off, 3'b000} +: 8];
    w_hword = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    unique case (i_ld_funct3)
      F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_ld_data = {24'd0, w_byte};
      F3_LH:   o_ld_data = {{16{w_hword[15]}}, w_hword};
      F3_LHU:  o_ld_data = {16'd0, w_hword};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RISC-V memory-access stage: issues data-memory requests for loads/stores,
// flags misaligned/illegal accesses and presents a registered writeback bundle.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd_addr,
  input  logic            reg_write,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            exc_valid,
  output logic [1:0]      exc_code
);

  state_t      r_state;
  logic        r_is_load;
  logic [2:0]  r_ld_f3;
  logic [1:0]  r_ld_off;
  logic        r_wen;

  logic        w_accept;
  logic        w_memop;
  logic        w_wen;
  logic        w_illegal;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;

  // Gated by rst so the stage never advertises readiness while held in reset.
  assign in_ready = !rst && (r_state == IDLE) && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_memop  = mem_read || mem_write;
  assign w_wen    = reg_write && (rd_addr != 5'd0);

  lsu_align u_align (
    .i_mem_read  (mem_read),
    .i_mem_write (mem_write),
    .i_funct3    (funct3),
    .i_addr_lo   (alu_result[1:0]),
    .i_rs2       (rs2_data),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_illegal   (w_illegal),
    .o_misalign  (w_misalign),
    .i_ld_funct3 (r_ld_f3),
    .i_ld_off    (r_ld_off),
    .i_rdata     (dmem_rdata),
    .o_ld_data   (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_is_load  <= 1'b0;
      r_ld_f3    <= '0;
      r_ld_off   <= '0;
      r_wen      <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      out_valid  <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      wb_we      <= 1'b0;
      exc_valid  <= 1'b0;
      exc_code   <= EXC_NONE;
    end else begin
      // Retire first; a same-cycle accept below overrides these defaults.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        wb_we     <= 1'b0;
        exc_valid <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            wb_rd <= rd_addr;
            if (w_memop && (w_illegal || w_misalign)) begin
              out_valid <= 1'b1;
              wb_we     <= 1'b0;
              wb_data   <= alu_result;
              exc_valid <= 1'b1;
              if (w_illegal)
                exc_code <= EXC_ILLEGAL;
              else
                exc_code <= mem_read ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
            end else if (w_memop) begin
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
              r_is_load  <= mem_read;
              r_ld_f3    <= funct3;
              r_ld_off   <= alu_result[1:0];
              r_wen      <= w_wen;
              r_state    <= REQ;
            end else begin
              out_valid <= 1'b1;
              wb_data   <= alu_result;
              wb_we     <= w_wen;
              exc_valid <= 1'b0;
              exc_code  <= EXC_NONE;
            end
          end
        end

        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (r_is_load) begin
              r_state <= WAIT;
            end else begin
              out_valid <= 1'b1;
              wb_we     <= 1'b0;
              exc_valid <= 1'b0;
              exc_code  <= EXC_NONE;
              r_state   <= IDLE;
            end
          end
        end

        WAIT: begin
          if (dmem_rvalid) begin
            out_valid <= 1'b1;
            wb_data   <= w_ld_data;
            wb_we     <= r_wen;
            exc_valid <= 1'b0;
            exc_code  <= EXC_NONE;
            r_state   <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, multi-cycle corner
// sequences and randomized operations against a behavioural reference model.
module tb_mem_stage;

  typedef struct {
    logic        rd_;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] rdata;
    int          gd;
  } op_t;

  typedef struct {
    logic        exc;
    logic [1:0]  code;
    logic        we;
    logic [31:0] data;
    logic        chk_data;
    logic        req;
    logic        dwe;
    logic [31:0] daddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
    int          lat;
    int          held;
  } exp_t;

  typedef struct {
    logic        got;
    logic        exc;
    logic [1:0]  code;
    logic        we;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        req;
    logic        dwe;
    logic [31:0] daddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stable;
    int          lat;
    int          held;
  } res_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] alu_result, rs2_data;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we, exc_valid;
  logic [1:0]  exc_code;

  int total = 0;
  int bad   = 0;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs2_data(rs2_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .rd_addr(rd_addr), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .exc_valid(exc_valid), .exc_code(exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic op_t mkop(logic r, logic w, logic [2:0] f3, logic [31:0] a,
                               logic [31:0] rs2, logic [4:0] rd, logic rw,
                               logic [31:0] rdata, int gd);
    op_t o;
    o.rd_ = r; o.wr = w; o.f3 = f3; o.addr = a; o.rs2 = rs2;
    o.rd = rd; o.rw = rw; o.rdata = rdata; o.gd = gd;
    return o;
  endfunction

  function automatic exp_t mkexp(logic exc, logic [1:0] code, logic we, logic [31:0] data,
                                 logic chkd, logic req, logic dwe, logic [31:0] daddr,
                                 logic [3:0] be, logic [31:0] wdata, logic chkw,
                                 int lat, int held);
    exp_t e;
    e.exc = exc; e.code = code; e.we = we; e.data = data; e.chk_data = chkd;
    e.req = req; e.dwe = dwe; e.daddr = daddr; e.be = be; e.wdata = wdata;
    e.chk_wdata = chkw; e.lat = lat; e.held = held;
    return e;
  endfunction

  // Reference model: access size in bytes, offset within the word, plain arithmetic.
  function automatic exp_t model(op_t o, int rv);
    exp_t        e;
    int          off, size;
    logic        memop, illegal;
    logic [31:0] v, mask;
    e = mkexp(0, 2'b00, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    memop   = o.rd_ || o.wr;
    off     = int'(o.addr % 32'd4);
    size    = 1 << o.f3[1:0];
    illegal = (o.rd_ && o.wr) ||
              (o.rd_ && (o.f3 == 3'd3 || o.f3 == 3'd6 || o.f3 == 3'd7)) ||
              (o.wr && o.f3 >= 3'd3);
    if (!memop) begin
      e.we = o.rw && (o.rd != 5'd0);
      e.data = o.addr;
      e.chk_data = 1'b1;
    end else if (illegal) begin
      e.exc = 1'b1; e.code = 2'b11;
    end else if ((off % size) != 0) begin
      e.exc = 1'b1; e.code = o.rd_ ? 2'b01 : 2'b10;
    end else begin
      e.req   = 1'b1;
      e.dwe   = o.wr;
      e.daddr = o.addr - 32'(off);
      e.be    = 4'(((1 << size) - 1) << off);
      e.held  = o.gd + 1;
      if (o.wr) begin
        e.chk_wdata = 1'b1;
        e.wdata = (size == 1) ? (o.rs2 & 32'hFF) * 32'h0101_0101 :
                  (size == 2) ? (o.rs2 & 32'hFFFF) * 32'h0001_0001 : o.rs2;
        e.lat = 2 + o.gd;
      end else begin
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        v = (o.rdata >> (8 * off)) & mask;
        if (!o.f3[2] && size < 4 && v[8 * size - 1])
          v = v - (32'd1 << (8 * size));
        e.data = v;
        e.chk_data = 1'b1;
        e.we = o.rw && (o.rd != 5'd0);
        e.lat = 2 + o.gd + rv;
      end
    end
    return e;
  endfunction

  task automatic drive(input op_t o);
    in_valid   = 1'b1;
    mem_read   = o.rd_;
    mem_write  = o.wr;
    funct3     = o.f3;
    alu_result = o.addr;
    rs2_data   = o.rs2;
    rd_addr    = o.rd;
    reg_write  = o.rw;
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic run_op(input op_t o, input int rv, output res_t r);
    int   cyc, k, since, lat;
    logic granted;
    r = '{default: '0};
    r.stable = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) return;
    drive(o);
    @(negedge clk);
    idle_in();
    lat = 1; k = 0; since = 0; granted = 1'b0;
    for (int c = 0; c < 40; c++) begin
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata = $urandom;
      if (out_valid) begin
        r.got = 1'b1; r.exc = exc_valid; r.code = exc_code; r.we = wb_we;
        r.data = wb_data; r.rd = wb_rd; r.lat = lat;
        break;
      end
      if (dmem_req) begin
        if (k == 0) begin
          r.req = 1'b1; r.dwe = dmem_we; r.daddr = dmem_addr;
          r.be = dmem_be; r.wdata = dmem_wdata;
        end else if (r.dwe !== dmem_we || r.daddr !== dmem_addr ||
                     r.be !== dmem_be || r.wdata !== dmem_wdata) begin
          r.stable = 1'b0;
        end
        r.held++;
        if (k == o.gd) begin
          dmem_gnt = 1'b1;
          granted = 1'b1;
        end
        k++;
      end else if (granted) begin
        since++;
        if (since == rv && !r.dwe) begin
          dmem_rvalid = 1'b1;
          dmem_rdata = o.rdata;
        end
      end
      @(negedge clk);
      lat++;
    end
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic check_res(input string tag, input op_t o, input exp_t e, input res_t r);
    chk({tag, ".done"}, 32'(r.got), 32'd1);
    if (r.got) begin
      chk({tag, ".exc"}, 32'(r.exc), 32'(e.exc));
      chk({tag, ".code"}, 32'(r.code), 32'(e.code));
      chk({tag, ".we"}, 32'(r.we), 32'(e.we));
      chk({tag, ".rd"}, 32'(r.rd), 32'(o.rd));
      if (e.chk_data) chk({tag, ".data"}, r.data, e.data);
      chk({tag, ".req"}, 32'(r.req), 32'(e.req));
      if (e.req) begin
        chk({tag, ".daddr"}, r.daddr, e.daddr);
        chk({tag, ".be"}, 32'(r.be), 32'(e.be));
        chk({tag, ".dwe"}, 32'(r.dwe), 32'(e.dwe));
        chk({tag, ".held"}, 32'(r.held), 32'(e.held));
        chk({tag, ".stable"}, 32'(r.stable), 32'd1);
        if (e.chk_wdata) chk({tag, ".wdata"}, r.wdata, e.wdata);
      end
      chk({tag, ".lat"}, 32'(r.lat), 32'(e.lat));
    end
  endtask

  localparam int NT = 15;
  vec_t tbl [NT];

  initial begin
    res_t        r;
    op_t         o;
    exp_t        e;
    logic [31:0] held_data;

    tbl[0]  = '{mkop(0,0,3'b000,32'h0000_1234,32'h0,5'd5,1,32'h0,0),
                mkexp(0,2'b00,1,32'h0000_1234,1, 0,0,32'h0,4'h0,32'h0,0, 1,0)};
    tbl[1]  = '{mkop(1,0,3'b000,32'h0000_0103,32'h0,5'd6,1,32'h80AA_BBCC,0),
                mkexp(0,2'b00,1,32'hFFFF_FF80,1, 1,0,32'h0000_0100,4'b1000,32'h0,0, 3,1)};
    tbl[2]  = '{mkop(1,0,3'b100,32'h0000_0103,32'h0,5'd6,1,32'h80AA_BBCC,0),
                mkexp(0,2'b00,1,32'h0000_0080,1, 1,0,32'h0000_0100,4'b1000,32'h0,0, 3,1)};
    tbl[3]  = '{mkop(0,1,3'b001,32'h0000_0202,32'h1234_ABCD,5'd7,1,32'h0,3),
                mkexp(0,2'b00,0,32'h0,0, 1,1,32'h0000_0200,4'b1100,32'hABCD_ABCD,1, 5,4)};
    tbl[4]  = '{mkop(1,0,3'b010,32'h0000_0301,32'h0,5'd8,1,32'h0,0),
                mkexp(1,2'b01,0,32'h0,0, 0,0,32'h0,4'h0,32'h0,0, 1,0)};
    tbl[5]  = '{mkop(0,1,3'b010,32'h0000_0302,32'h0,5'd9,1,32'h0,0),
                mkexp(1,2'b10,0,32'h0,0, 0,0,32'h0,4'h0,32'h0,0, 1,0)};
    tbl[6]  = '{mkop(1,1,3'b010,32'h0000_0400,32'h0,5'd10,1,32'h0,0),
                mkexp(1,2'b11,0,32'h0,0, 0,0,32'h0,4'h0,32'h0,0, 1,0)};
    tbl[7]  = '{mkop(1,0,3'b001,32'h0000_0102,32'h0,5'd11,1,32'h80AA_BBCC,0),
                mkexp(0,2'b00,1,32'hFFFF_80AA,1, 1,0,32'h0000_0100,4'b1100,32'h0,0, 3,1)};
    tbl[8]  = '{mkop(1,0,3'b101,32'h0000_0100,32'h0,5'd12,1,32'h80AA_BBCC,0),
                mkexp(0,2'b00,1,32'h0000_BBCC,1, 1,0,32'h0000_0100,4'b0011,32'h0,0, 3,1)};
    tbl[9]  = '{mkop(1,0,3'b010,32'h0000_0300,32'h0,5'd0,1,32'hDEAD_BEEF,0),
                mkexp(0,2'b00,0,32'hDEAD_BEEF,1, 1,0,32'h0000_0300,4'b1111,32'h0,0, 3,1)};
    tbl[10] = '{mkop(0,1,3'b000,32'h0000_0001,32'h1234_5655,5'd13,1,32'h0,0),
                mkexp(0,2'b00,0,32'h0,0, 1,1,32'h0000_0000,4'b0010,32'h5555_5555,1, 2,1)};
    tbl[11] = '{mkop(1,0,3'b011,32'h0000_0000,32'h0,5'd14,1,32'h0,0),
                mkexp(1,2'b11,0,32'h0,0, 0,0,32'h0,4'h0,32'h0,0, 1,0)};
    tbl[12] = '{mkop(0,1,3'b011,32'h0000_0000,32'h0,5'd15,1,32'h0,0),
                mkexp(1,2'b11,0,32'h0,0, 0,0,32'h0,4'h0,32'h0,0, 1,0)};
    tbl[13] = '{mkop(0,0,3'b000,32'hFFFF_0000,32'h0,5'd0,1,32'h0,0),
                mkexp(0,2'b00,0,32'hFFFF_0000,1, 0,0,32'h0,4'h0,32'h0,0, 1,0)};
    tbl[14] = '{mkop(1,0,3'b001,32'h0000_0101,32'h0,5'd16,1,32'h0,0),
                mkexp(1,2'b01,0,32'h0,0, 0,0,32'h0,4'h0,32'h0,0, 1,0)};

    rst = 1'b1;
    idle_in();
    alu_result = '0; rs2_data = '0; funct3 = '0; rd_addr = '0; reg_write = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst.ctrl", {26'd0, in_ready, dmem_req, dmem_we, out_valid, wb_we, exc_valid}, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.wbdata", wb_data, 32'd0);
    chk("rst.misc", {21'd0, dmem_be, wb_rd, exc_code}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NT; i++) begin
      run_op(tbl[i].op, 1, r);
      check_res($sformatf("vec%0d", i), tbl[i].op, tbl[i].e, r);
    end

    // Back-to-back pass-through bundles at one per cycle.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(mkop(0, 0, 3'b000, 32'h1000 + 32'(i * 'h111), 32'h0, 5'(i + 1), 1, 32'h0, 0));
      @(negedge clk);
      chk($sformatf("b2b%0d.valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b%0d.data", i), wb_data, 32'h1000 + 32'(i * 'h111));
      chk($sformatf("b2b%0d.ready", i), 32'(in_ready), 32'd1);
    end
    idle_in();
    @(negedge clk);
    chk("b2b.drain", 32'(out_valid), 32'd0);

    // Backpressure holds the load result and blocks new requests.
    out_ready = 1'b0;
    o = mkop(1, 0, 3'b010, 32'h0000_0400, 32'h0, 5'd3, 1, 32'h0BAD_F00D, 0);
    run_op(o, 1, r);
    check_res("bp", o, model(o, 1), r);
    held_data = wb_data;
    drive(mkop(1, 0, 3'b010, 32'h0000_0500, 32'h0, 5'd4, 1, 32'h0, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d.data", i), wb_data, held_data);
      chk($sformatf("bp%0d.inrdy", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d.req", i), 32'(dmem_req), 32'd0);
    end
    idle_in();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.retire", 32'(out_valid), 32'd0);
    chk("bp.noreq", 32'(dmem_req), 32'd0);

    // Reset while the request is outstanding drops dmem_req at once.
    drive(mkop(1, 0, 3'b010, 32'h0000_0700, 32'h0, 5'd5, 1, 32'h0, 0));
    @(negedge clk);
    idle_in();
    chk("rreq.req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rreq.ctrl", {29'd0, dmem_req, out_valid, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rreq.after", 32'(dmem_req), 32'd0);

    // Reset while waiting for read data; a late rvalid must be ignored.
    drive(mkop(1, 0, 3'b010, 32'h0000_0800, 32'h0, 5'd6, 1, 32'h0, 0));
    @(negedge clk);
    idle_in();
    chk("rwait.req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rwait.reqdrop", 32'(dmem_req), 32'd0);
    rst = 1'b1;
    #1;
    chk("rwait.ctrl", {29'd0, dmem_req, out_valid, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rwait.ign%0d", i), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    o = mkop(1, 0, 3'b010, 32'h0000_0900, 32'h0, 5'd7, 1, 32'h1357_9BDF, 0);
    run_op(o, 1, r);
    check_res("rwait.next", o, model(o, 1), r);

    // Randomized operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      int kind, rv;
      kind = int'($urandom_range(0, 9));
      o.rd_   = (kind >= 2 && kind <= 5) || kind == 9;
      o.wr    = (kind >= 6 && kind <= 8) || kind == 9;
      o.f3    = 3'($urandom_range(0, 7));
      o.addr  = $urandom;
      o.rs2   = $urandom;
      o.rd    = 5'($urandom_range(0, 31));
      o.rw    = 1'($urandom_range(0, 1));
      o.rdata = $urandom;
      o.gd    = int'($urandom_range(0, 3));
      rv      = int'($urandom_range(1, 3));
      e = model(o, rv);
      run_op(o, rv, r);
      check_res($sformatf("rnd%0d", i), o, e, r);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage sitting directly downstream of execute_stage in the RISC-V pipeline.
- Takes the 32-bit ALU result as the effective address, or as pass-through writeback data.
- Performs byte/half/word loads and stores over a request/grant/rvalid data-memory interface.
- Aligns and sign- or zero-extends load data, and presents a registered writeback bundle with a valid/ready handshake to the writeback stage.

Parameters:
XLEN, 32, datapath and address width (only 32 supported)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  execute-stage bundle valid
in_ready  out  1  stage can accept a bundle
alu_result  in  32  effective address, or pass-through data
rs2_data  in  32  store data
mem_read  in  1  load instruction
mem_write  in  1  store instruction
funct3  in  3  access width/sign (RV32I load/store encoding)
rd_addr  in  5  destination register
reg_write  in  1  instruction writes rd
dmem_req  out  1  memory request (registered)
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data
out_valid  out  1  writeback bundle valid
out_ready  in  1  writeback stage accepts
wb_data  out  32  writeback data
wb_rd  out  5  destination register
wb_we  out  1  register write enable
exc_valid  out  1  exception accompanies bundle
exc_code  out  2  01 load-misaligned, 10 store-misaligned, 11 illegal access

Behaviour:
- Reset (asynchronous): state IDLE; in_ready, dmem_req, dmem_we, out_valid, wb_we, exc_valid = 0; dmem_addr, dmem_be, dmem_wdata, wb_data, wb_rd, exc_code = 0.
  - Reset mid-transaction drops dmem_req immediately; the in-flight access is abandoned and a later rvalid is ignored.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A bundle is accepted on in_valid && in_ready.
- States: IDLE, REQ, WAIT.
- IDLE, accept, no memory op: next cycle out_valid=1, wb_data=alu_result, wb_we=reg_write && rd_addr!=0. Latency 1.
- IDLE, accept, illegal access: next cycle out_valid=1, exc_valid=1, wb_we=0, no dmem_req. Illegal means any of:
  - mem_read && mem_write;
  - load funct3 in {011,110,111};
  - store funct3 >= 011.
- IDLE, accept, misaligned access: next cycle out_valid=1, exc_valid=1, code 01 (load) or 10 (store), wb_we=0, no dmem_req. Misaligned means:
  - half with addr[0]=1;
  - word with addr[1:0]!=0.
- IDLE, accept, legal memory op: next cycle dmem_req=1 and state REQ.
  - dmem_addr/be/wdata/we stay stable until grant.
  - be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - wdata: byte replicated x4; half replicated x2.
- REQ: dmem_req held until dmem_gnt. The cycle after gnt, dmem_req=0.
  - Store: out_valid=1, wb_we=0; return to IDLE.
  - Load: go to WAIT.
- WAIT: on dmem_rvalid, latch the extracted lane.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Next cycle out_valid=1, wb_data = extended value, wb_we = reg_write && rd!=0; state IDLE.
  - Minimum load latency is 3 cycles with zero-wait gnt and rvalid one cycle after gnt.
- dmem_rvalid is sampled only in WAIT. rvalid in the same cycle as gnt is not supported; the memory guarantees rvalid ≥1 cycle after gnt.
- Output hold: while out_valid && !out_ready, all wb_*/exc_* outputs are stable and in_ready=0. The bundle retires on out_valid && out_ready.
- Simultaneous retire and accept in IDLE is allowed, giving back-to-back throughput of 1 per cycle for non-memory ops.
- An exception bundle never asserts wb_we.

Decomposition:
- riscv_pkg holds:
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW;
  - state enum IDLE/REQ/WAIT;
  - exc_code constants EXC_LD_MISALIGN, EXC_ST_MISALIGN, EXC_ILLEGAL.
- One combinational sub-module, lsu_align, contains:
  - be/wdata generation;
  - misalign/illegal detection;
  - load lane extraction and extension.

Test Plan:
- Pass-through: alu_result=0x0000_1234, rd=5, reg_write=1, out_ready=1 -> next cycle out_valid=1, wb_data=0x1234, wb_we=1; back-to-back bundles at 1/cycle.
- LB at addr 0x103, dmem_rdata=0x80AA_BBCC -> dmem_addr=0x100, be=1000, wb_data=0xFFFF_FF80. The same access as LBU -> 0x0000_0080.
- SH at 0x202, rs2=0x1234_ABCD, gnt delayed 3 cycles -> dmem_req held 4 cycles with stable addr 0x200, be=1100, wdata=0xABCD_ABCD; then out_valid, wb_we=0.
- LW at 0x301 -> no dmem_req; out_valid with exc_valid=1, exc_code=01. SW at 0x302 -> exc_code=10. mem_read=mem_write=1 -> 11.
- Backpressure: out_ready=0 for 5 cycles after LW result -> wb_data stable, in_ready=0, no new dmem_req.
- rst asserted in WAIT -> dmem_req, out_valid, in_ready = 0 immediately. A later rvalid is ignored; the next LW completes normally.
